psum_out_fifo: RTL
==================

# psum_out_fifo

Output collector for the systolic MAC array. It sits directly below the last `mac_row` and captures that row's per-column partial sums (`out_s`) under its per-column `valid` strobes. Those strobes arrive skewed by one cycle per column. The block buffers each column in its own FIFO and presents complete, column-aligned output rows to the downstream consumer (SFU/accumulator or SRAM writeback) through a simple valid/read handshake.

## Interface
- `col`, default 8: number of columns (independent FIFOs).
- `psum_bw`, default 16: partial-sum width per column.
- `depth`, default 64: entries per column. Must be a power of 2, at least 2.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low (asserted at 0). Clears all state immediately. Release is synchronous to `clk` at the system level.
- `in`, input, `psum_bw*col`: column i data is `in[psum_bw*(i+1)-1 : psum_bw*i]`. Driven by `mac_row.out_s`.
- `wr`, input, `col`: per-column write strobe. Driven by `mac_row.valid`.
- `rd`, input, 1: pop one aligned row. Honoured only when `o_valid`=1.
- `out`, output, `psum_bw*col`: registered row data, same packing as `in`.
- `o_valid`, output, 1: every column FIFO holds at least one entry.
- `o_full`, output, 1: at least one column FIFO holds `depth` entries.
- `o_ready`, output, 1: equals `~o_full`. The array controller stalls execution when this is 0.
- `o_overflow`, output, 1: sticky. Set when any write is dropped. Cleared only by reset.

## Operation
- **Storage.** Each column has its own storage of `depth` x `psum_bw`, a write pointer and a read pointer. Pointers are `log2(depth)+1` bits wide; the MSB is the wrap bit.
  - Column i is empty when its pointers are fully equal.
  - Column i is full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo `2*depth` with no special handling.
- **Write.** On an edge with `wr[i]`=1:
  - If column i is not full (evaluated before the edge), write `in` slice i at `wptr[i]` and increment `wptr[i]`.
  - If column i is full, drop the data, leave the pointer unchanged, and set `o_overflow`.
  - The full check uses pre-edge state, so a write to a full column is dropped even if a read pops on the same edge.
- **Read.** On an edge with `rd`=1 and `o_valid`=1:
  - For every column i, `out` slice i is loaded with `mem[i][rptr[i]]` and all read pointers increment together.
  - Columns are always popped in lockstep, so row alignment is preserved.
- **Read ignored.** `rd`=1 with `o_valid`=0 has no effect: `out` holds and the pointers hold.
- **Simultaneous read and write** on a non-full column: both occur and the occupancy of that column is unchanged.
- **Write to an empty column** with `rd` on the same edge: `o_valid` was 0 before the edge, so the read is ignored. The written entry becomes readable from the next cycle.
- **Status decode.** `o_valid`, `o_full` and `o_ready` are combinational from the pointers (registered state), so they are glitch-free relative to `clk`.
- **Reset.**
  - Every pointer, `out`, `o_valid`, `o_full` and `o_overflow` go to 0, and `o_ready` goes to 1.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all buffered rows and any partial (skewed) row. The next row starts clean from column 0.

## Timing
- **Write to visibility: 1 cycle.** A write on edge k is counted in occupancy after edge k.
- **Skewed input.** With `wr` arriving as a one-hot strobe moving from column 0 at edge k to column `col-1` at edge k+`col-1`:
  - `o_valid` rises after edge k+`col-1`.
  - The row can be popped at edge k+`col` at the earliest.
- **Read latency: 1 edge.** With `rd` and `o_valid` high before edge m:
  - `out` shows the popped row after edge m.
  - `o_valid` and `o_full` reflect the pop after edge m.
- **Throughput.** Back-to-back reads are allowed: one row per cycle while `o_valid` stays high.
- **Hold.** `out` holds its last popped row indefinitely until the next accepted read or reset.
- **Full and ready.** `o_full` and `o_ready` change on the same edge as the write or read that causes them.

## Test plan
- **Reset values.** Assert `reset`=0 mid-stream with 5 rows buffered, then release. Required: `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1, `o_overflow`=0. A subsequent write of 1 row reads back that row only.
- **Skewed single row.** `wr` one-hot 0x01, 0x02, ... 0x80 on consecutive edges, with column i data = 0x100+i. Required: `o_valid` rises exactly one cycle after the 0x80 strobe. After `rd` the `out` slices read 0x100 to 0x107, then `o_valid`=0.
- **Fill and overflow** (`depth`=64). Write 64 full rows with `wr`=0xFF, data = row index. Required: `o_full`=1 and `o_ready`=0 after the 64th write. A 65th write with data 0xDEAD is dropped and sets `o_overflow`=1. Draining with 64 reads returns 0 to 63 in order.
- **Simultaneous read/write at steady state.** With 10 rows buffered, assert `rd` and `wr`=0xFF together for 100 cycles. Required: occupancy stays 10, `o_valid` stays 1, and output values are in strict FIFO order.
- **Pointer wrap.** Push and pop 300 rows with random gaps (occupancy never above 64). Required: all 300 rows read back bit-exact and in order, and `o_overflow` stays 0.
- **Read when empty or partial.** With only columns 0 to 3 written, assert `rd`. Required: `out` unchanged, pointers unchanged, `o_valid`=0. After columns 4 to 7 are written, the read pops the aligned row.

Source files
------------

// File: rtl/psum_out_fifo.sv
// psum_out_fifo: output collector below the last mac_row.
// Each column's partial sums arrive under their own (skewed) valid strobe.
// Every column is buffered in a private FIFO. Complete rows are popped in
// lockstep, so the downstream consumer always sees column-aligned rows.

module psum_out_fifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64   // power of 2, >= 2
) (
  input  logic                   clk,
  input  logic                   reset,      // async, active-low
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  localparam int aw = $clog2(depth);

  // The extra MSB is the wrap bit. It tells full apart from empty when the
  // address bits are equal.
  typedef logic [aw:0] ptr_t;

  logic [psum_bw-1:0] mem [col][depth];
  ptr_t               wptr [col];
  ptr_t               rptr [col];

  logic [col-1:0] col_empty;
  logic [col-1:0] col_full;
  logic [col-1:0] wr_ok;
  logic           rd_ok;

  // Per-column status decode from registered pointers; write qualification.
  // NOTE: every output of an always_comb gets a default before any
  // conditional logic, so no path can leave it unassigned and infer a latch.
  always_comb begin
    col_empty = '0;
    col_full  = '0;
    wr_ok     = '0;
    for (int i = 0; i < col; i++) begin
      col_empty[i] = (wptr[i] == rptr[i]);
      col_full[i]  = (wptr[i][aw-1:0] == rptr[i][aw-1:0]) &&
                     (wptr[i][aw] != rptr[i][aw]);
      wr_ok[i]     = wr[i] && !col_full[i];
    end
  end

  assign o_valid = ~|col_empty;
  assign o_full  = |col_full;
  assign o_ready = ~o_full;
  assign rd_ok   = rd && o_valid;

  // Column storage. A write to a full column is dropped. The full check uses
  // pre-edge state, so a pop on the same edge does not make room in time.
  // NOTE: the storage array has no reset. Its contents are unreachable until
  // the pointers advance past a written entry. A reset term would also stop
  // the array from mapping onto RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_ok[i]) begin
        mem[i][wptr[i][aw-1:0]] <= in[psum_bw*i +: psum_bw];
      end
    end
  end

  // Pointer update. All read pointers move together, so rows stay aligned.
  // NOTE: sequential state uses non-blocking assignments only. Every
  // always_ff then sees pre-edge values, regardless of evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < col; i++) begin
        if (wr_ok[i]) wptr[i] <= wptr[i] + ptr_t'(1);
        if (rd_ok)    rptr[i] <= rptr[i] + ptr_t'(1);
      end
    end
  end

  // Registered output row. It is loaded only on an accepted pop and holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= '0;
    end else if (rd_ok) begin
      for (int i = 0; i < col; i++) begin
        out[psum_bw*i +: psum_bw] <= mem[i][rptr[i][aw-1:0]];
      end
    end
  end

  // Sticky overflow flag. Any dropped write sets it, and only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_overflow <= 1'b0;
    end else if (|(wr & col_full)) begin
      o_overflow <= 1'b1;
    end
  end

endmodule
